div_sequencer: RTL

- Multi-cycle controller for the RV32M divide/remainder instructions (DIV, DIVU, REM, REMU).
- Sits beside the EX stage and drives the shared alu_core in subtract mode, one restoring-division step per cycle.
- Handles sign correction and RISC-V special cases locally; the pipeline stalls on busy and captures the result on done.

---
 rtl/div_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer driving a shared ALU, one restoring step per cycle.
// Latency: 1 cycle to done for div-by-zero/overflow, else 34; start is ignored (not queued) while busy or done.
module div_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_alu_a,
    output logic [XLEN-1:0] o_alu_b,
    output logic [4:0]      o_alu_control,
    input  logic [XLEN-1:0] i_alu_result,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_NOP = 5'b00000;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_op_rem;
    logic              r_q_neg;
    logic              r_r_neg;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_div;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_result;

    logic              w_signed;
    logic              w_dvd_neg;
    logic              w_dvs_neg;
    logic [XLEN-1:0]   w_abs_dvd;
    logic [XLEN-1:0]   w_abs_dvs;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN-1:0]   w_shift;
    logic              w_borrow;
    logic              w_ge;
    logic [XLEN-1:0]   w_fix_res;

    assign w_signed  = ~i_op[0];
    assign w_dvd_neg = w_signed & i_dividend[XLEN-1];
    assign w_dvs_neg = w_signed & i_divisor[XLEN-1];
    assign w_abs_dvd = w_dvd_neg ? (~i_dividend + 1'b1) : i_dividend;
    assign w_abs_dvs = w_dvs_neg ? (~i_divisor + 1'b1) : i_divisor;
    assign w_div0    = (i_divisor == '0);
    assign w_ovf     = w_signed & (i_dividend == {1'b1, {(XLEN-1){1'b0}}}) & (&i_divisor);
    assign w_special = w_div0 | w_ovf;
    // Overflow DIV returns the dividend itself (0x80000000), overflow REM returns 0.
    assign w_special_res = w_div0 ? (i_op[1] ? i_dividend : '1)
                                  : (i_op[1] ? '0 : i_dividend);

    assign w_shift  = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
    assign w_borrow = (~w_shift[XLEN-1] & r_div[XLEN-1])
                    | (~(w_shift[XLEN-1] ^ r_div[XLEN-1]) & i_alu_result[XLEN-1]);
    // rem[MSB] is the bit shifted out of w_shift: the true partial remainder exceeds the divisor.
    assign w_ge     = r_rem[XLEN-1] | ~w_borrow;

    assign w_fix_res = r_op_rem ? (r_r_neg ? (~r_rem + 1'b1) : r_rem)
                                : (r_q_neg ? (~r_quo + 1'b1) : r_quo);

    assign o_result = r_result;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        o_alu_a       = '0;
        o_alu_b       = '0;
        o_alu_control = ALU_NOP;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = w_special ? S_DONE : S_ITER;
                end
            end
            S_ITER: begin
                o_busy        = 1'b1;
                o_alu_a       = w_shift;
                o_alu_b       = r_div;
                o_alu_control = ALU_SUB;
                if (i_flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == {CNT_W{1'b1}}) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                o_busy      = 1'b1;
                w_state_nxt = i_flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_op_rem <= 1'b0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_op_rem <= i_op[1];
                        r_q_neg  <= w_dvd_neg ^ w_dvs_neg;
                        r_r_neg  <= w_dvd_neg;
                        r_div    <= w_abs_dvs;
                        r_rem    <= '0;
                        r_quo    <= w_abs_dvd;
                        r_cnt    <= '0;
                        if (w_special) begin
                            r_result <= w_special_res;
                        end
                    end
                end
                S_ITER: begin
                    if (!i_flush) begin
                        r_rem <= w_ge ? i_alu_result : w_shift;
                        r_quo <= {r_quo[XLEN-2:0], w_ge};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    if (!i_flush) begin
                        r_result <= w_fix_res;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
